// File: rtl/data_mem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access sequencer.
// Covers FSM state encoding, access sizes, RV64 funct3 codes and the alignment rule.
package data_mem_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} dmem_state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // An access is aligned when the byte offset is a multiple of its size.
    function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
        logic bad;
        unique case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = |off[1:0];
            default: bad = |off;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_access_ctrl_lane_align.sv
// Byte-lane steering between a 64-bit memory word and a sized register value.
// Purely combinational: extracts and extends loads, merges store bytes into the read word.
module mem_lane_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [2:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [63:0] rdata_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] load_o,
    output logic [63:0] merge_o
);

    logic [5:0]  shamt;
    logic [63:0] field;
    logic [63:0] lane_mask;
    logic [63:0] shifted_mask;

    assign shamt = {off_i, 3'b000};

    always_comb begin
        field     = rdata_i >> shamt;
        lane_mask = '1;
        load_o    = field;
        unique case (size_i)
            SZ_B: begin
                lane_mask = 64'h0000_0000_0000_00FF;
                load_o    = {{56{~unsigned_i & field[7]}}, field[7:0]};
            end
            SZ_H: begin
                lane_mask = 64'h0000_0000_0000_FFFF;
                load_o    = {{48{~unsigned_i & field[15]}}, field[15:0]};
            end
            SZ_W: begin
                lane_mask = 64'h0000_0000_FFFF_FFFF;
                load_o    = {{32{~unsigned_i & field[31]}}, field[31:0]};
            end
            default: begin
                lane_mask = '1;
                load_o    = field;
            end
        endcase
        shifted_mask = lane_mask << shamt;
        merge_o      = (rdata_i & ~shifted_mask) | ((wdata_i << shamt) & shifted_mask);
    end

endmodule

// File: rtl/data_mem_access_ctrl.sv
// Load/store sequencer between the multicycle control FSM and a 64-bit data memory.
// Start is taken only in IDLE; Done pulses after RD_LATENCY+1 (load), +2 (sub-dword store), 2 (SD) or 1 (reject).
module data_mem_access_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 64,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              IsStore,
    input  logic [2:0]        Funct3,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] StoreData,
    input  logic [DATA_W-1:0] DMemRData,
    output logic [ADDR_W-1:0] DMemAddr,
    output logic              DMemWrite,
    output logic [DATA_W-1:0] DMemWData,
    output logic [DATA_W-1:0] LoadData,
    output logic              Busy,
    output logic              Done,
    output logic              Misaligned
);

    localparam logic [2:0] CNT_INIT = 3'(RD_LATENCY - 1);

    dmem_state_t       state_q;
    logic              store_q;
    logic [2:0]        f3_q;
    logic [2:0]        off_q;
    logic [2:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] sdata_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] load_q;

    logic              bad_req;
    logic [DATA_W-1:0] ext_load;
    logic [DATA_W-1:0] merged;

    assign bad_req = is_misaligned(Addr[2:0], Funct3[1:0]) || (IsStore && Funct3[2]);

    mem_lane_align u_lane_align (
        .off_i      (off_q),
        .size_i     (f3_q[1:0]),
        .unsigned_i (f3_q[2]),
        .rdata_i    (DMemRData),
        .wdata_i    (sdata_q),
        .load_o     (ext_load),
        .merge_o    (merged)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            wdata_q <= '0;
            load_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Start) begin
                        store_q <= IsStore;
                        f3_q    <= Funct3;
                        off_q   <= Addr[2:0];
                        sdata_q <= StoreData;
                        addr_q  <= {Addr[ADDR_W-1:3], 3'b000};
                        cnt_q   <= CNT_INIT;
                        if (bad_req) begin
                            state_q <= ERR;
                        end else if (IsStore && (Funct3[1:0] == SZ_D)) begin
                            // Full doubleword: nothing to preserve, skip the read.
                            wdata_q <= StoreData;
                            state_q <= WRITE;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    if (cnt_q == 3'd0) begin
                        if (store_q) begin
                            wdata_q <= merged;
                            state_q <= WRITE;
                        end else begin
                            load_q  <= ext_load;
                            state_q <= DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                WRITE:   state_q <= DONE;
                DONE:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from the state register so reset kills them at once.
    assign DMemWrite  = (state_q == WRITE);
    assign Busy       = (state_q != IDLE);
    assign Done       = (state_q == DONE) || (state_q == ERR);
    assign Misaligned = (state_q == ERR);
    assign DMemAddr   = addr_q;
    assign DMemWData  = wdata_q;
    assign LoadData   = load_q;

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Randomized bench for data_mem_access_ctrl: two instances (read latency 1 and 3) share stimulus,
// each with its own memory; results are compared with a byte-level reference model.
module tb_data_mem_access_ctrl;
    import data_mem_ctrl_pkg::*;

    localparam int NDUT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] sdata;

    logic [63:0] rdata [NDUT];
    logic [63:0] maddr [NDUT];
    logic [63:0] wdat  [NDUT];
    logic [63:0] ldat  [NDUT];
    logic        mwr   [NDUT];
    logic        busy  [NDUT];
    logic        done  [NDUT];
    logic        mis   [NDUT];

    logic [63:0] mem [NDUT][16];
    logic [63:0] ref_mem [16];
    logic [63:0] ref_load;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        assign rdata[g] = mem[g][maddr[g][6:3]];
        data_mem_access_ctrl #(
            .DATA_W     (64),
            .ADDR_W     (64),
            .RD_LATENCY ((g == 0) ? 1 : 3)
        ) u_dut (
            .clk        (clk),
            .Reset      (rst),
            .Start      (start),
            .IsStore    (is_store),
            .Funct3     (f3),
            .Addr       (addr),
            .StoreData  (sdata),
            .DMemRData  (rdata[g]),
            .DMemAddr   (maddr[g]),
            .DMemWrite  (mwr[g]),
            .DMemWData  (wdat[g]),
            .LoadData   (ldat[g]),
            .Busy       (busy[g]),
            .Done       (done[g]),
            .Misaligned (mis[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, want 0x%h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_bad(input bit st, input logic [2:0] fn, input logic [63:0] a);
        int n = 1 << fn[1:0];
        return ((int'(a[2:0]) % n) != 0) || (st && fn[2]);
    endfunction

    function automatic logic [63:0] ref_extract(input logic [63:0] word, input logic [2:0] fn,
                                                input logic [63:0] a);
        int n = 1 << fn[1:0];
        int off = int'(a[2:0]);
        logic [63:0] r = '0;
        for (int b = 0; b < n; b++) r[8*b +: 8] = word[8*(off+b) +: 8];
        if (n < 8 && !fn[2] && r[8*n-1])
            for (int b = n; b < 8; b++) r[8*b +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic [63:0] ref_merge(input logic [63:0] old, input logic [63:0] sd,
                                              input logic [2:0] fn, input logic [63:0] a);
        int n = 1 << fn[1:0];
        int off = int'(a[2:0]);
        logic [63:0] r = old;
        for (int b = 0; b < n; b++) r[8*(off+b) +: 8] = sd[8*b +: 8];
        return r;
    endfunction

    task automatic set_word(input int idx, input logic [63:0] v);
        ref_mem[idx] = v;
        for (int d = 0; d < NDUT; d++) mem[d][idx] = v;
    endtask

    // Called at a falling edge with both instances idle; returns one cycle after the last Done.
    task automatic do_op(input string nm, input bit st, input logic [2:0] fn, input logic [63:0] a,
                         input logic [63:0] sd);
        bit          bad;
        int          idx;
        logic [63:0] exp_w;
        int          exp_done [NDUT];
        int          done_k   [NDUT];
        int          wr_k     [NDUT];
        int          wr_n     [NDUT];
        logic [63:0] wr_d     [NDUT];
        logic        mis_v    [NDUT];
        logic [63:0] addr_v   [NDUT];

        bad   = ref_bad(st, fn, a);
        idx   = int'(a[6:3]);
        exp_w = ref_merge(ref_mem[idx], sd, fn, a);
        for (int d = 0; d < NDUT; d++) begin
            exp_done[d] = bad ? 1 : (st && fn[1:0] == 2'b11) ? 2 : st ? lat_of(d) + 2 : lat_of(d) + 1;
            done_k[d] = 0; wr_k[d] = 0; wr_n[d] = 0; wr_d[d] = '0; mis_v[d] = 1'b0; addr_v[d] = '0;
        end

        start = 1'b1; is_store = st; f3 = fn; addr = a; sdata = sd;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Garbage after Start must be ignored, including a second Start while busy.
                start    = 1'($urandom_range(0, 1));
                is_store = 1'($urandom);
                f3       = 3'($urandom);
                addr     = {$urandom, $urandom};
                sdata    = {$urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            for (int d = 0; d < NDUT; d++) begin
                if (mwr[d]) begin
                    wr_n[d]++;
                    wr_k[d] = k;
                    wr_d[d] = wdat[d];
                    mem[d][maddr[d][6:3]] = wdat[d];
                end
                if (done[d] && done_k[d] == 0) begin
                    done_k[d] = k;
                    mis_v[d]  = mis[d];
                    addr_v[d] = maddr[d];
                end
            end
            if (done_k[0] != 0 && done_k[1] != 0) break;
        end
        start = 1'b0;

        if (!st && !bad) ref_load = ref_extract(ref_mem[idx], fn, a);
        if (st && !bad) ref_mem[idx] = exp_w;

        for (int d = 0; d < NDUT; d++) begin
            check_eq($sformatf("%s/L%0d/done_cycle", nm, lat_of(d)), 64'(done_k[d]), 64'(exp_done[d]));
            check_eq($sformatf("%s/L%0d/misaligned", nm, lat_of(d)), 64'(mis_v[d]), 64'(bad));
            check_eq($sformatf("%s/L%0d/write_count", nm, lat_of(d)), 64'(wr_n[d]), 64'(st && !bad));
            if (st && !bad) begin
                check_eq($sformatf("%s/L%0d/write_cycle", nm, lat_of(d)), 64'(wr_k[d]), 64'(exp_done[d] - 1));
                check_eq($sformatf("%s/L%0d/wdata", nm, lat_of(d)), wr_d[d], exp_w);
            end
            check_eq($sformatf("%s/L%0d/addr", nm, lat_of(d)), addr_v[d], {a[63:3], 3'b000});
            check_eq($sformatf("%s/L%0d/load_data", nm, lat_of(d)), ldat[d], ref_load);
        end

        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check_eq($sformatf("%s/L%0d/idle_busy", nm, lat_of(d)), 64'(busy[d]), 64'(0));
            check_eq($sformatf("%s/L%0d/idle_done", nm, lat_of(d)), 64'(done[d]), 64'(0));
        end
    endtask

    initial begin
        int          wr_seen;
        bit          st;
        logic [1:0]  sz;
        logic [2:0]  fn;
        logic [63:0] a;

        ref_load = '0;
        for (int i = 0; i < 16; i++) set_word(i, {$urandom, $urandom});

        // Reset for two cycles with a live SD request on the inputs.
        rst = 1'b1; start = 1'b1; is_store = 1'b1; f3 = F3_SD; addr = 64'h10;
        sdata = 64'h1122_3344_5566_7788;
        repeat (2) @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check_eq($sformatf("reset/L%0d/busy", lat_of(d)), 64'(busy[d]), 64'(0));
            check_eq($sformatf("reset/L%0d/done", lat_of(d)), 64'(done[d]), 64'(0));
            check_eq($sformatf("reset/L%0d/mis", lat_of(d)), 64'(mis[d]), 64'(0));
            check_eq($sformatf("reset/L%0d/mwr", lat_of(d)), 64'(mwr[d]), 64'(0));
            check_eq($sformatf("reset/L%0d/maddr", lat_of(d)), maddr[d], 64'h0);
            check_eq($sformatf("reset/L%0d/wdata", lat_of(d)), wdat[d], 64'h0);
            check_eq($sformatf("reset/L%0d/ldata", lat_of(d)), ldat[d], 64'h0);
        end

        do_op("sd", 1'b1, F3_SD, 64'h10, 64'h1122_3344_5566_7788);
        check_eq("sd/mem_const", mem[0][2], 64'h1122_3344_5566_7788);

        set_word(2, '1);
        do_op("sb", 1'b1, F3_SB, 64'h13, 64'h0000_0000_0000_00AB);
        check_eq("sb/mem_const", mem[0][2], 64'hFFFF_FFFF_ABFF_FFFF);

        set_word(3, 64'h8000_0000_0000_0000);
        do_op("lb", 1'b0, F3_LB, 64'h1F, 64'h0);
        check_eq("lb/load_const", ldat[1], 64'hFFFF_FFFF_FFFF_FF80);
        do_op("lbu", 1'b0, F3_LBU, 64'h1F, 64'h0);
        check_eq("lbu/load_const", ldat[1], 64'h0000_0000_0000_0080);

        do_op("lw_misaligned", 1'b0, F3_LW, 64'h12, 64'h0);
        do_op("store_f3_100", 1'b1, 3'b100, 64'h10, 64'hAB);

        // Reset while SH at 0x16 is in READ: no write may escape.
        start = 1'b1; is_store = 1'b1; f3 = F3_SH; addr = 64'h16; sdata = 64'hBEEF;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check_eq($sformatf("rst_mid/L%0d/busy", lat_of(d)), 64'(busy[d]), 64'(0));
            check_eq($sformatf("rst_mid/L%0d/mwr", lat_of(d)), 64'(mwr[d]), 64'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        ref_load = '0;
        wr_seen = 0;
        repeat (5) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) if (mwr[d]) wr_seen++;
        end
        check_eq("rst_mid/write_seen", 64'(wr_seen), 64'(0));
        for (int d = 0; d < NDUT; d++)
            check_eq($sformatf("rst_mid/L%0d/mem", lat_of(d)), mem[d][2], ref_mem[2]);
        do_op("sh_after_rst", 1'b1, F3_SH, 64'h16, 64'h0000_0000_0000_BEEF);

        for (int i = 0; i < 300; i++) begin
            st = 1'($urandom);
            sz = 2'($urandom);
            fn = {($urandom_range(0, 7) == 0) ? 1'b1 : (st ? 1'b0 : 1'($urandom)), sz};
            a  = 64'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << sz) - 1);
            do_op($sformatf("rnd%0d", i), st, fn, a, {$urandom, $urandom});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
